// File: rtl/csi_pkg.sv
// Shared types and constants for the CSI-2 frame capture controller.
package csi_pkg;

  localparam int unsigned CSI_WORD_BYTES = 4;
  localparam int unsigned CSI_WORD_WIDTH = CSI_WORD_BYTES * 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_CAPTURE,
    S_DRAIN,
    S_DONE
  } capture_state_t;

endpackage

// File: rtl/csi_word_fifo.sv
// Shift-register word FIFO: the head entry is always r_mem[0], so the read
// data and the full/empty flags all come straight from flops.
module csi_word_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [CW-1:0]    r_count;
  logic             r_full;
  logic             r_empty;
  logic [CW-1:0]    w_count_nxt;
  logic [CW-1:0]    w_wr_idx;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign w_pop_ok    = i_pop && !r_empty;
  assign w_push_ok   = i_push && !r_full;
  assign w_count_nxt = r_count + CW'(w_push_ok) - CW'(w_pop_ok);
  // A simultaneous pop shifts everything down, so the new word lands one slot lower.
  assign w_wr_idx    = r_count - CW'(w_pop_ok);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else if (i_flush) begin
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (w_pop_ok) begin
        for (int i = 0; i < int'(DEPTH) - 1; i++) r_mem[i] <= r_mem[i+1];
      end
      if (w_push_ok) r_mem[AW'(w_wr_idx)] <= i_push_data;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CW'(DEPTH));
      r_empty <= (w_count_nxt == '0);
    end
  end

  assign o_rd_data = r_mem[0];
  assign o_full    = r_full;
  assign o_empty   = r_empty;

endmodule

// File: rtl/csi_frame_capture_ctrl.sv
// Captures one CSI-2 frame (or a stream of frames) of 32-bit payload words
// into a word-addressed buffer through a small FIFO and valid/ready port.
module csi_frame_capture_ctrl
  import csi_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                      clock_p,
  input  logic                      reset_n,
  input  logic                      arm,
  input  logic                      abort,
  input  logic                      continuous,
  input  logic [ADDR_WIDTH:0]       max_words,
  input  logic                      sof,
  input  logic                      eof,
  input  logic                      word_valid,
  input  logic [CSI_WORD_WIDTH-1:0] word_data,
  output logic                      wr_valid,
  input  logic                      wr_ready,
  output logic [ADDR_WIDTH-1:0]     wr_addr,
  output logic [CSI_WORD_WIDTH-1:0] wr_data,
  output logic                      busy,
  output logic                      done,
  output logic [15:0]               frame_count,
  output logic [ADDR_WIDTH:0]       words_captured,
  output logic                      overflow,
  output logic                      truncated,
  output logic                      sync_error
);

  capture_state_t            r_state;
  capture_state_t            w_state_nxt;
  logic [1:0]                r_rst_sync;
  logic                      w_rst_n;
  logic [ADDR_WIDTH-1:0]     r_wr_addr;
  logic [ADDR_WIDTH:0]       r_words_captured;
  logic [ADDR_WIDTH:0]       r_words_accepted;
  logic [15:0]               r_frame_count;
  logic                      r_busy;
  logic                      r_done;
  logic                      r_overflow;
  logic                      r_truncated;
  logic                      r_sync_error;
  logic                      w_fifo_full;
  logic                      w_fifo_empty;
  logic [CSI_WORD_WIDTH-1:0] w_fifo_rd_data;
  logic                      w_arm_ok;
  logic                      w_start;
  logic                      w_in_capture;
  logic                      w_take;
  logic                      w_limit;
  logic                      w_push;
  logic                      w_wr_fire;

  // Assert asynchronously, release on a clock edge.
  always_ff @(posedge clock_p or negedge reset_n) begin
    if (!reset_n) r_rst_sync <= 2'b00;
    else          r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  assign w_arm_ok     = !abort && (r_state == S_IDLE) && arm;
  assign w_start      = !abort && (r_state == S_ARMED) && sof;
  assign w_in_capture = !abort && (r_state == S_CAPTURE);
  assign w_take       = w_in_capture && word_valid;
  assign w_limit      = (r_words_accepted >= max_words);
  assign w_push       = w_take && !w_fifo_full && !w_limit;
  assign w_wr_fire    = wr_valid && wr_ready;

  csi_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CSI_WORD_WIDTH)
  ) u_fifo (
    .i_clk       (clock_p),
    .i_rst_n     (w_rst_n),
    .i_flush     (abort),
    .i_push      (w_push),
    .i_push_data (word_data),
    .i_pop       (w_wr_fire),
    .o_rd_data   (w_fifo_rd_data),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty)
  );

  always_ff @(posedge clock_p or negedge w_rst_n) begin
    if (!w_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:    if (arm) w_state_nxt = S_ARMED;
        S_ARMED:   if (sof) w_state_nxt = S_CAPTURE;
        S_CAPTURE: if (eof) w_state_nxt = S_DRAIN;
        S_DRAIN:   if (w_fifo_empty) w_state_nxt = S_DONE;
        S_DONE:    w_state_nxt = continuous ? S_ARMED : S_IDLE;
        default:   w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock_p or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_wr_addr        <= '0;
      r_words_captured <= '0;
      r_words_accepted <= '0;
      r_frame_count    <= '0;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
      r_overflow       <= 1'b0;
      r_truncated      <= 1'b0;
      r_sync_error     <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt != S_IDLE);
      r_done <= (w_state_nxt == S_DONE);
      if (w_state_nxt == S_DONE) r_frame_count <= r_frame_count + 16'd1;
      // The FIFO is always empty when a frame starts, so no write can race the restart.
      if (w_start) begin
        r_wr_addr        <= '0;
        r_words_captured <= '0;
        r_words_accepted <= '0;
      end else begin
        if (w_wr_fire) begin
          r_wr_addr        <= r_wr_addr + ADDR_WIDTH'(1);
          r_words_captured <= r_words_captured + (ADDR_WIDTH+1)'(1);
        end
        if (w_push) r_words_accepted <= r_words_accepted + (ADDR_WIDTH+1)'(1);
      end
      if (w_arm_ok) begin
        r_overflow   <= 1'b0;
        r_truncated  <= 1'b0;
        r_sync_error <= 1'b0;
      end else begin
        if (w_take && w_fifo_full) r_overflow   <= 1'b1;
        if (w_take && w_limit)     r_truncated  <= 1'b1;
        if (w_in_capture && sof)   r_sync_error <= 1'b1;
      end
    end
  end

  assign wr_valid       = !w_fifo_empty;
  assign wr_data        = w_fifo_rd_data;
  assign wr_addr        = r_wr_addr;
  assign busy           = r_busy;
  assign done           = r_done;
  assign frame_count    = r_frame_count;
  assign words_captured = r_words_captured;
  assign overflow       = r_overflow;
  assign truncated      = r_truncated;
  assign sync_error     = r_sync_error;

endmodule

// File: tb/tb_csi_frame_capture_ctrl.sv
// Directed bench for csi_frame_capture_ctrl: frame, backpressure, limit,
// continuous, abort and asynchronous reset scenarios.
module tb_csi_frame_capture_ctrl;

  localparam int unsigned AW = 16;
  localparam int unsigned FD = 4;

  logic          clock_p;
  logic          reset_n;
  logic          arm;
  logic          abort;
  logic          continuous;
  logic [AW:0]   max_words;
  logic          sof;
  logic          eof;
  logic          word_valid;
  logic [31:0]   word_data;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          busy;
  logic          done;
  logic [15:0]   frame_count;
  logic [AW:0]   words_captured;
  logic          overflow;
  logic          truncated;
  logic          sync_error;

  int n_checks;
  int n_fail;
  logic [AW-1:0] q_addr [$];
  logic [31:0]   q_data [$];

  csi_frame_capture_ctrl #(
    .ADDR_WIDTH (AW),
    .FIFO_DEPTH (FD)
  ) dut (
    .clock_p        (clock_p),
    .reset_n        (reset_n),
    .arm            (arm),
    .abort          (abort),
    .continuous     (continuous),
    .max_words      (max_words),
    .sof            (sof),
    .eof            (eof),
    .word_valid     (word_valid),
    .word_data      (word_data),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .busy           (busy),
    .done           (done),
    .frame_count    (frame_count),
    .words_captured (words_captured),
    .overflow       (overflow),
    .truncated      (truncated),
    .sync_error     (sync_error)
  );

  initial begin
    clock_p = 1'b0;
    forever #5 clock_p = ~clock_p;
  end

  // Record every completed buffer write.
  always @(posedge clock_p) begin
    if (reset_n && wr_valid && wr_ready) begin
      q_addr.push_back(wr_addr);
      q_data.push_back(wr_data);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock_p);
    #1;
  endtask

  task automatic pulse_arm();
    arm = 1'b1; tick(); arm = 1'b0;
  endtask

  task automatic pulse_sof();
    sof = 1'b1; tick(); sof = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] d);
    word_valid = 1'b1; word_data = d; tick(); word_valid = 1'b0;
  endtask

  task automatic run_window(input int n, output int dones);
    dones = 0;
    repeat (n) begin
      tick();
      if (done) dones++;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (4) tick();
  endtask

  task automatic chk_writes(input string tag, input int n,
                            input logic [AW-1:0] a0, input logic [31:0] d0);
    chk({tag, "_nwr"}, 64'(q_addr.size()), 64'(n));
    for (int i = 0; i < n && i < q_addr.size(); i++) begin
      chk({tag, "_addr"}, 64'(q_addr[i]), 64'(a0 + AW'(i)));
      chk({tag, "_data"}, 64'(q_data[i]), 64'(d0 + 32'(i)));
    end
  endtask

  initial begin
    int nd;
    n_checks = 0; n_fail = 0;
    reset_n = 1'b0; arm = 1'b0; abort = 1'b0; continuous = 1'b0;
    max_words = (AW+1)'(100); sof = 1'b0; eof = 1'b0; word_valid = 1'b0;
    word_data = '0; wr_ready = 1'b1;
    #12;
    chk("rst_wr_valid", 64'(wr_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_fcnt", 64'(frame_count), 64'd0);
    reset_n = 1'b1;
    repeat (4) tick();

    // Single frame of 8 words, no backpressure.
    pulse_arm();
    chk("t1_busy_armed", 64'(busy), 64'd1);
    pulse_sof();
    for (int i = 0; i < 8; i++) send_word(32'(i));
    eof = 1'b1; tick(); eof = 1'b0;
    run_window(30, nd);
    chk("t1_done_pulses", 64'(nd), 64'd1);
    chk("t1_fcnt", 64'(frame_count), 64'd1);
    chk("t1_idle", 64'(busy), 64'd0);
    chk("t1_wcap", 64'(words_captured), 64'd8);
    chk_writes("t1", 8, '0, 32'h0);

    // Backpressure: 6 words into a 4-deep FIFO.
    q_addr.delete(); q_data.delete();
    wr_ready = 1'b0;
    pulse_arm();
    pulse_sof();
    for (int i = 0; i < 6; i++) send_word(32'h100 + 32'(i));
    chk("t2_wr_valid", 64'(wr_valid), 64'd1);
    chk("t2_wr_addr", 64'(wr_addr), 64'd0);
    chk("t2_wr_data", 64'(wr_data), 64'h100);
    chk("t2_overflow", 64'(overflow), 64'd1);
    chk("t2_trunc", 64'(truncated), 64'd0);
    eof = 1'b1; tick(); eof = 1'b0;
    repeat (3) tick();
    chk("t2_hold_data", 64'(wr_data), 64'h100);
    chk("t2_hold_busy", 64'(busy), 64'd1);
    wr_ready = 1'b1;
    run_window(30, nd);
    chk("t2_done_pulses", 64'(nd), 64'd1);
    chk("t2_wcap", 64'(words_captured), 64'd4);
    chk_writes("t2", 4, '0, 32'h100);

    // Limit of 3 words; arm+sof together must not start the frame.
    q_addr.delete(); q_data.delete();
    max_words = (AW+1)'(3);
    arm = 1'b1; sof = 1'b1; tick(); arm = 1'b0; sof = 1'b0;
    chk("t3_arm_clr_ovf", 64'(overflow), 64'd0);
    chk("t3_busy", 64'(busy), 64'd1);
    send_word(32'hDEAD);
    tick();
    chk("t3_armed_no_wr", 64'(wr_valid), 64'd0);
    pulse_sof();
    for (int i = 0; i < 5; i++) send_word(32'h200 + 32'(i));
    eof = 1'b1; tick(); eof = 1'b0;
    run_window(30, nd);
    chk("t3_done_pulses", 64'(nd), 64'd1);
    chk("t3_trunc", 64'(truncated), 64'd1);
    chk("t3_ovf", 64'(overflow), 64'd0);
    chk("t3_wcap", 64'(words_captured), 64'd3);
    chk("t3_fcnt", 64'(frame_count), 64'd3);
    chk_writes("t3", 3, '0, 32'h200);

    // Continuous: two 2-word frames, second word of each coincides with eof.
    do_reset();
    q_addr.delete(); q_data.delete();
    max_words = (AW+1)'(100); continuous = 1'b1;
    pulse_arm();
    for (int f = 0; f < 2; f++) begin
      pulse_sof();
      send_word(32'h300 + 32'(f*16));
      eof = 1'b1; send_word(32'h301 + 32'(f*16)); eof = 1'b0;
      run_window(20, nd);
      chk("t4_done_pulses", 64'(nd), 64'd1);
    end
    chk("t4_fcnt", 64'(frame_count), 64'd2);
    chk("t4_armed_busy", 64'(busy), 64'd1);
    chk("t4_wcap", 64'(words_captured), 64'd2);
    chk("t4_nwr", 64'(q_addr.size()), 64'd4);
    if (q_addr.size() == 4) begin
      chk("t4_a0", 64'(q_addr[0]), 64'd0); chk("t4_d0", 64'(q_data[0]), 64'h300);
      chk("t4_a1", 64'(q_addr[1]), 64'd1); chk("t4_d1", 64'(q_data[1]), 64'h301);
      chk("t4_a2", 64'(q_addr[2]), 64'd0); chk("t4_d2", 64'(q_data[2]), 64'h310);
      chk("t4_a3", 64'(q_addr[3]), 64'd1); chk("t4_d3", 64'(q_data[3]), 64'h311);
    end

    // Abort mid-capture with a write pending, plus a stray sof.
    continuous = 1'b0;
    abort = 1'b1; tick(); abort = 1'b0;
    chk("t5_abort_idle", 64'(busy), 64'd0);
    pulse_arm();
    pulse_sof();
    wr_ready = 1'b0;
    send_word(32'hA5A5_0001);
    send_word(32'hA5A5_0002);
    pulse_sof();
    chk("t5_sync_err", 64'(sync_error), 64'd1);
    chk("t5_addr_kept", 64'(wr_addr), 64'd0);
    chk("t5_still_cap", 64'(busy), 64'd1);
    chk("t5_pending", 64'(wr_valid), 64'd1);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("t5_wr_dropped", 64'(wr_valid), 64'd0);
    chk("t5_busy", 64'(busy), 64'd0);
    q_addr.delete(); q_data.delete();
    wr_ready = 1'b1;
    repeat (3) tick();
    chk("t5_flushed", 64'(wr_valid), 64'd0);
    chk("t5_no_writes", 64'(q_addr.size()), 64'd0);

    // Asynchronous reset in the middle of a frame and a stalled write.
    pulse_arm();
    pulse_sof();
    send_word(32'hA5A5_0003);
    tick();
    wr_ready = 1'b0;
    send_word(32'hA5A5_0004);
    pulse_sof();
    chk("t6_pre_wcap", 64'(words_captured), 64'd1);
    chk("t6_pre_valid", 64'(wr_valid), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_wr_valid", 64'(wr_valid), 64'd0);
    chk("t6_wr_addr", 64'(wr_addr), 64'd0);
    chk("t6_wr_data", 64'(wr_data), 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_done", 64'(done), 64'd0);
    chk("t6_fcnt", 64'(frame_count), 64'd0);
    chk("t6_wcap", 64'(words_captured), 64'd0);
    chk("t6_flags", 64'({overflow, truncated, sync_error}), 64'd0);
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
